// File: rtl/key_debouncer.sv
// Debounces raw key pins per channel and emits clean levels plus one-cycle
// press, release and long-press pulses; every channel has its own counters.
module key_debouncer #(
    parameter int NumKeys         = 4,
    parameter int DebounceCycles  = 500000,
    parameter int LongPressCycles = 50000000,
    parameter bit ActiveLow       = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NumKeys-1:0] key_raw,
    output logic [NumKeys-1:0] key_state,
    output logic [NumKeys-1:0] key_press,
    output logic [NumKeys-1:0] key_release,
    output logic [NumKeys-1:0] key_long
);

    localparam int DbW   = $clog2(DebounceCycles);
    localparam int HoldW = $clog2(LongPressCycles + 1);

    localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LongPressCycles);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressCycles - 1);

    genvar gi;
    generate
        for (gi = 0; gi < NumKeys; gi++) begin : g_key
            logic             sync1_reg;
            logic             sync2_reg;
            logic             state_reg;
            logic             press_reg;
            logic             release_reg;
            logic             long_reg;
            logic [DbW-1:0]   db_cnt_reg;
            logic [HoldW-1:0] hold_cnt_reg;
            logic             sample;
            logic             db_done;

            assign sample  = sync2_reg ^ ActiveLow;
            // A release accepted on this edge must not coincide with a long pulse.
            assign db_done = (sample != state_reg) && (db_cnt_reg == DbLast);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg    <= ActiveLow;
                    sync2_reg    <= ActiveLow;
                    state_reg    <= 1'b0;
                    press_reg    <= 1'b0;
                    release_reg  <= 1'b0;
                    long_reg     <= 1'b0;
                    db_cnt_reg   <= '0;
                    hold_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= key_raw[gi];
                    sync2_reg   <= sync1_reg;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    long_reg    <= 1'b0;

                    if (sample == state_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_done) begin
                        state_reg   <= sample;
                        db_cnt_reg  <= '0;
                        press_reg   <= sample;
                        release_reg <= ~sample;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DbW'(1);
                    end

                    // Saturating at the threshold keeps key_long to one pulse per press.
                    if (!state_reg) begin
                        hold_cnt_reg <= '0;
                    end else if (hold_cnt_reg != HoldMax) begin
                        hold_cnt_reg <= hold_cnt_reg + HoldW'(1);
                        long_reg     <= (hold_cnt_reg == HoldLast) && !db_done;
                    end
                end
            end

            assign key_state[gi]   = state_reg;
            assign key_press[gi]   = press_reg;
            assign key_release[gi] = release_reg;
            assign key_long[gi]    = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios with literal expectations plus a
// randomized bounce stream checked every cycle against a cycle-count model.
module tb_key_debouncer;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int LP = 10;
    localparam bit AL = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_raw = {NK{AL}};
    logic [NK-1:0] key_state, key_press, key_release, key_long;

    int checks = 0;
    int errors = 0;

    key_debouncer #(
        .NumKeys(NK), .DebounceCycles(DB), .LongPressCycles(LP), .ActiveLow(AL)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .key_state(key_state),
        .key_press(key_press), .key_release(key_release), .key_long(key_long)
    );

    always #5 clk = ~clk;

    // Model: pipeline delay of two samples, then count consecutive disagreeing
    // samples and count cycles spent pressed.
    logic [NK-1:0] m_s1 = {NK{AL}};
    logic [NK-1:0] m_s2 = {NK{AL}};
    logic [NK-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;
    int            m_run[NK];
    int            m_hold[NK];
    bit            was_pressed, pressed_now, releasing;

    initial begin
        for (int k = 0; k < NK; k++) begin
            m_run[k]  = 0;
            m_hold[k] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = {NK{AL}};
            m_s2 = {NK{AL}};
            m_state = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k]  = 0;
                m_hold[k] = 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                was_pressed = m_state[k];
                pressed_now = m_s2[k] ^ AL;
                releasing   = 1'b0;
                m_press[k] = 1'b0; m_rel[k] = 1'b0; m_long[k] = 1'b0;
                if (pressed_now != was_pressed) begin
                    m_run[k]++;
                    if (m_run[k] == DB) begin
                        m_state[k] = pressed_now;
                        m_run[k]   = 0;
                        m_press[k] = pressed_now;
                        m_rel[k]   = !pressed_now;
                        releasing  = !pressed_now;
                    end
                end else begin
                    m_run[k] = 0;
                end
                if (was_pressed) begin
                    if (m_hold[k] < LP) begin
                        m_hold[k]++;
                        if (m_hold[k] == LP && !releasing) m_long[k] = 1'b1;
                    end
                end else begin
                    m_hold[k] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_raw;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks += 4;
            if (key_state !== m_state) begin
                errors++;
                $display("FAIL cmp_state t=%0t: dut=%b model=%b", $time, key_state, m_state);
            end
            if (key_press !== m_press) begin
                errors++;
                $display("FAIL cmp_press t=%0t: dut=%b model=%b", $time, key_press, m_press);
            end
            if (key_release !== m_rel) begin
                errors++;
                $display("FAIL cmp_release t=%0t: dut=%b model=%b", $time, key_release, m_rel);
            end
            if (key_long !== m_long) begin
                errors++;
                $display("FAIL cmp_long t=%0t: dut=%b model=%b", $time, key_long, m_long);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    task automatic watch(input int ch, input int n, output int t_press, output int n_press,
                         output int t_long, output int n_long, output int t_rel);
        t_press = -1; n_press = 0; t_long = -1; n_long = 0; t_rel = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (key_press[ch]) begin
                n_press++;
                if (t_press < 0) t_press = i;
            end
            if (key_long[ch]) begin
                n_long++;
                if (t_long < 0) t_long = i;
            end
            if (key_release[ch] && t_rel < 0) t_rel = i;
        end
    endtask

    int tp, np, tl, nl, tr, act;
    int dwell[NK];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_state", int'(key_state), 0);
        check("reset_pulses", int'(key_press | key_release | key_long), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("idle_state", int'(key_state), 0);

        // Clean press on key 0, then clean release
        key_raw[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("press_edge5_state", int'(key_state[0]), 0);
        @(negedge clk);
        check("press_edge6_state", int'(key_state[0]), 1);
        check("press_edge6_pulse", int'(key_press[0]), 1);
        check("press_other_key", int'(key_press[1] | key_state[1]), 0);
        @(negedge clk);
        check("press_one_cycle", int'(key_press[0]), 0);
        key_raw[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("release_edge5", int'(key_release[0]), 0);
        @(negedge clk);
        check("release_edge6_pulse", int'(key_release[0]), 1);
        check("release_edge6_state", int'(key_state[0]), 0);
        repeat (4) @(negedge clk);

        // Bounce: 3 low, 1 high, 3 low, high
        act = 0;
        for (int i = 0; i < 15; i++) begin
            key_raw[0] = !(i < 3 || (i >= 4 && i < 7));
            @(negedge clk);
            act += int'(key_state[0] | key_press[0] | key_release[0]);
        end
        check("bounce_no_activity", act, 0);
        key_raw[0] = 1'b0;
        watch(0, 12, tp, np, tl, nl, tr);
        check("bounce_then_hold_presses", np, 1);
        key_raw[0] = 1'b1;
        repeat (12) @(negedge clk);

        // Long press on key 1
        key_raw[1] = 1'b0;
        watch(1, 30, tp, np, tl, nl, tr);
        check("long_press_at", tp, 6);
        check("long_delay", tl - tp, LP);
        check("long_count", nl, 1);
        key_raw[1] = 1'b1;
        watch(1, 20, tp, np, tl, nl, tr);
        check("long_release_at", tr, 6);
        check("long_after_release", nl, 0);
        repeat (4) @(negedge clk);

        // Short press: key_state high for 8 cycles only
        key_raw[1] = 1'b0;
        watch(1, 8, tp, np, tl, nl, tr);
        check("short_press_at", tp, 6);
        key_raw[1] = 1'b1;
        watch(1, 20, tp, np, tl, nl, tr);
        check("short_no_long", nl, 0);
        check("short_release_at", tr, 6);
        key_raw[1] = 1'b0;
        watch(1, 30, tp, np, tl, nl, tr);
        check("repress_long_delay", tl - tp, LP);
        check("repress_long_count", nl, 1);
        key_raw[1] = 1'b1;
        repeat (12) @(negedge clk);

        // Simultaneous keys
        key_raw = 2'b00;
        for (int i = 0; i < 20 && key_press == '0; i++) @(negedge clk);
        check("simul_press", int'(key_press), 3);
        repeat (3) @(negedge clk);
        key_raw[0] = 1'b1;
        repeat (12) @(negedge clk);
        check("simul_release_one", int'(key_state), 2);

        // Asynchronous reset with keys held
        key_raw[0] = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", int'(key_state), 0);
        check("async_rst_pulses", int'(key_press | key_release | key_long), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        act = 0;
        repeat (5) begin
            @(negedge clk);
            act += int'(key_press != 0);
        end
        check("post_rst_no_early_press", act, 0);
        @(negedge clk);
        check("post_rst_press", int'(key_press), 3);

        // Randomized bounce stream with occasional mid-cycle resets
        key_raw = {NK{AL}};
        repeat (12) @(negedge clk);
        for (int k = 0; k < NK; k++) dwell[k] = 1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(999) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
            for (int k = 0; k < NK; k++) begin
                dwell[k]--;
                if (dwell[k] <= 0) begin
                    key_raw[k] = ~key_raw[k];
                    dwell[k] = ($urandom_range(1) == 0) ? int'($urandom_range(1, 3))
                                                       : int'($urandom_range(5, 25));
                end
            end
        end
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
